// File: rtl/memory_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : memory_responder
//  Purpose  : Single-port line memory behind a fixed-latency request/response
//             handshake. A level request (read or write) is accepted in IDLE.
//             The access then spends LATENCY cycles in BUSY. The result is
//             presented in RESP until the initiator drops its request.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_clock    in   1           sole clock, rising edge
//    i_reset    in   1           synchronous active-high reset
//    i_address  in   ADDR_WIDTH  byte address of the requested line
//    i_read     in   1           read request (level, held until o_ready)
//    i_write    in   1           write request (level, held until o_done)
//    i_data     in   LINE_WIDTH  write data (whole line)
//    o_data     out  LINE_WIDTH  read data, valid while o_ready=1
//    o_ready    out  1           read complete
//    o_done     out  1           write complete
//    o_error    out  1           access rejected (qualifies o_ready/o_done)
//    o_busy     out  1           high in BUSY and RESP
// ============================================================================
module memory_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_WIDTH  = 256,
  parameter int DEPTH_LINES = 1024,
  parameter int LATENCY     = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic                  i_read,
  input  logic                  i_write,
  input  logic [LINE_WIDTH-1:0] i_data,
  output logic [LINE_WIDTH-1:0] o_data,
  output logic                  o_ready,
  output logic                  o_done,
  output logic                  o_error,
  output logic                  o_busy
);

  // Address decomposition: OFF low bits select a byte inside a line and are
  // ignored. The next IDXW bits select the line.
  localparam int OFF  = $clog2(LINE_WIDTH / 8);
  localparam int IDXW = $clog2(DEPTH_LINES);
  localparam int SPAN = OFF + IDXW;
  // The latched address is zero-extended to at least SPAN+1 bits. Then
  // "address >= DEPTH_LINES*LINE_WIDTH/8" reduces to "any bit at or above
  // SPAN is set". This holds even when the bus is narrower than the memory.
  localparam int PADW = (ADDR_WIDTH > SPAN) ? ADDR_WIDTH : SPAN + 1;
  localparam int CNTW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Access kind is {write, read} as sampled at acceptance.
  localparam logic [1:0] K_READ  = 2'b01;
  localparam logic [1:0] K_WRITE = 2'b10;
  localparam logic [1:0] K_BOTH  = 2'b11;

  logic [1:0]            state_q, state_d;
  logic [CNTW-1:0]       cnt_q,   cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic [1:0]            kind_q,  kind_d;
  logic [LINE_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ready_q, ready_d;
  logic                  done_q,  done_d;
  logic                  error_q, error_d;
  logic                  busy_q,  busy_d;

  logic [LINE_WIDTH-1:0] mem_q [DEPTH_LINES];

  logic [PADW-1:0]       w_addr_ext;
  logic [IDXW-1:0]       w_idx;
  logic                  w_oor;
  logic                  w_hold;
  logic                  w_mem_we;
  logic                  w_unused_low;

  assign w_addr_ext   = PADW'(addr_q);
  assign w_idx        = w_addr_ext[SPAN-1:OFF];
  assign w_oor        = |w_addr_ext[PADW-1:SPAN];
  assign w_unused_low = ^w_addr_ext[OFF-1:0];

  // RESP is held by whichever request started the access. A conflicting
  // (read+write) access is held by either one.
  always_comb begin
    w_hold = 1'b0;
    case (kind_q)
      K_READ:  w_hold = i_read;
      K_WRITE: w_hold = i_write;
      K_BOTH:  w_hold = i_read | i_write;
      default: w_hold = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    kind_d   = kind_q;
    rdata_d  = rdata_q;
    ready_d  = ready_q;
    done_d   = done_q;
    error_d  = error_q;
    busy_d   = busy_q;
    w_mem_we = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_read | i_write) begin
          addr_d  = i_address;
          wdata_d = i_data;
          kind_d  = {i_write, i_read};
          busy_d  = 1'b1;
          state_d = S_BUSY;
          // A conflicting request skips the latency. It spends a single
          // BUSY cycle, so its response appears on the edge after acceptance.
          if (i_read & i_write) begin
            cnt_d = '0;
          end else begin
            cnt_d = CNTW'(LATENCY - 1);
          end
        end
      end

      S_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNTW'(1);
        end else begin
          state_d = S_RESP;
          case (kind_q)
            K_READ: begin
              ready_d = 1'b1;
              error_d = w_oor;
              rdata_d = w_oor ? '0 : mem_q[w_idx];
            end
            K_WRITE: begin
              done_d   = 1'b1;
              error_d  = w_oor;
              rdata_d  = '0;
              w_mem_we = ~w_oor;
            end
            default: begin
              ready_d = 1'b1;
              done_d  = 1'b1;
              error_d = 1'b1;
              rdata_d = '0;
            end
          endcase
        end
      end

      S_RESP: begin
        // The exit edge only returns to IDLE. A request present on this edge
        // is not looked at until the next edge, which is taken in IDLE.
        if (!w_hold) begin
          ready_d = 1'b0;
          done_d  = 1'b0;
          error_d = 1'b0;
          rdata_d = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Reset on the commit edge aborts the write.
    if (i_reset) begin
      w_mem_we = 1'b0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      kind_q  <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      kind_q  <= kind_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      error_q <= error_d;
      busy_q  <= busy_d;
    end
  end

  // Storage is never cleared by reset. Only whole lines are written.
  always_ff @(posedge i_clock) begin
    if (w_mem_we) begin
      mem_q[w_idx] <= wdata_q;
    end
  end

  assign o_data  = rdata_q;
  assign o_ready = ready_q;
  assign o_done  = done_q;
  assign o_error = error_q;
  assign o_busy  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_memory_responder
//  Purpose  : Self-checking bench for memory_responder. Expected responses
//             are queued when a request is driven and compared when the DUT
//             responds. A line model tracks committed writes.
//  Revision : 1.0  initial release
// ============================================================================
module tb_memory_responder;

  localparam int AW   = 32;
  localparam int LW   = 256;
  localparam int DL   = 1024;
  localparam int LAT  = 4;
  localparam int OFFB = 5;
  localparam int IDXB = 10;
  localparam logic [AW-1:0] LIMIT = AW'(DL * LW / 8);

  logic          i_clock = 1'b0;
  logic          i_reset = 1'b1;
  logic [AW-1:0] i_address = '0;
  logic          i_read = 1'b0;
  logic          i_write = 1'b0;
  logic [LW-1:0] i_data = '0;
  logic [LW-1:0] o_data;
  logic          o_ready;
  logic          o_done;
  logic          o_error;
  logic          o_busy;

  memory_responder #(
    .ADDR_WIDTH (AW),
    .LINE_WIDTH (LW),
    .DEPTH_LINES(DL),
    .LATENCY    (LAT)
  ) dut (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_address(i_address),
    .i_read   (i_read),
    .i_write  (i_write),
    .i_data   (i_data),
    .o_data   (o_data),
    .o_ready  (o_ready),
    .o_done   (o_done),
    .o_error  (o_error),
    .o_busy   (o_busy)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    logic [LW-1:0] data;
    logic          rdy;
    logic          dn;
    logic          err;
    int            lat;
  } exp_t;

  exp_t          sb[$];
  exp_t          last;
  logic [LW-1:0] model [int];
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] fill(input logic [7:0] b);
    return {(LW/8){b}};
  endfunction

  // Queue the expected response, update the line model, drive the request.
  task automatic start_req(input logic rd, input logic wr, input logic [AW-1:0] addr,
                           input logic [LW-1:0] wd);
    exp_t e;
    int   idx;
    logic oor;
    oor   = (addr >= LIMIT);
    idx   = int'(addr[OFFB+IDXB-1:OFFB]);
    e.data = '0;
    e.rdy  = 1'b0;
    e.dn   = 1'b0;
    e.err  = 1'b0;
    e.lat  = LAT;
    if (rd && wr) begin
      e.rdy = 1'b1; e.dn = 1'b1; e.err = 1'b1; e.lat = 1;
    end else if (rd) begin
      e.rdy = 1'b1; e.err = oor;
      if (!oor) e.data = model.exists(idx) ? model[idx] : 'x;
    end else begin
      e.dn = 1'b1; e.err = oor;
      if (!oor) model[idx] = wd;
    end
    sb.push_back(e);
    i_read = rd; i_write = wr; i_address = addr; i_data = wd;
  endtask

  // Count edges from the drive point until a response is seen. After the
  // acceptance edge the address/data inputs are scrambled (and the request
  // optionally withdrawn) to show that latched values are used.
  task automatic wait_resp(input int accept_edge, input bit withdraw);
    int   n;
    bit   seen;
    exp_t e;
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge i_clock); #1;
      n++;
      if (n == accept_edge) begin
        check("busy_after_accept", LW'(o_busy), LW'(1));
        i_address = AW'($urandom_range(0, int'(LIMIT) - 1));
        i_data    = {8{$urandom}};
        if (withdraw) begin i_read = 1'b0; i_write = 1'b0; end
      end
      if (o_ready || o_done) seen = 1'b1;
    end
    if (!seen) begin
      check("response_timeout", LW'(0), LW'(1));
      return;
    end
    if (sb.size() == 0) begin
      check("scoreboard_empty", LW'(0), LW'(1));
      return;
    end
    e = sb.pop_front();
    check("resp_edges", LW'(n), LW'(accept_edge + e.lat));
    check("o_ready",    LW'(o_ready), LW'(e.rdy));
    check("o_done",     LW'(o_done),  LW'(e.dn));
    check("o_error",    LW'(o_error), LW'(e.err));
    check("o_data",     o_data,       e.data);
    check("o_busy_resp", LW'(o_busy), LW'(1));
    last = e;
  endtask

  // Keep the request up for 'hold' cycles, then drop it and expect a clean exit.
  task automatic release_resp(input int hold);
    for (int h = 0; h < hold; h++) begin
      @(posedge i_clock); #1;
      check("hold_ready", LW'(o_ready), LW'(last.rdy));
      check("hold_done",  LW'(o_done),  LW'(last.dn));
      check("hold_data",  o_data,       last.data);
    end
    i_read = 1'b0; i_write = 1'b0;
    @(posedge i_clock); #1;
    check("exit_ready", LW'(o_ready), LW'(0));
    check("exit_done",  LW'(o_done),  LW'(0));
    check("exit_error", LW'(o_error), LW'(0));
    check("exit_data",  o_data,       LW'(0));
    check("exit_busy",  LW'(o_busy),  LW'(0));
  endtask

  task automatic do_access(input logic rd, input logic wr, input logic [AW-1:0] addr,
                           input logic [LW-1:0] wd, input int hold);
    start_req(rd, wr, addr, wd);
    wait_resp(1, 1'b0);
    release_resp(hold);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] ra;
    logic [LW-1:0] rd;

    // Reset state
    repeat (3) @(posedge i_clock);
    #1;
    check("rst_ready", LW'(o_ready), LW'(0));
    check("rst_done",  LW'(o_done),  LW'(0));
    check("rst_error", LW'(o_error), LW'(0));
    check("rst_busy",  LW'(o_busy),  LW'(0));
    check("rst_data",  o_data,       LW'(0));
    i_reset = 1'b0;
    @(posedge i_clock); #1;

    // Write A5 line, read back through another byte of the same line
    do_access(1'b0, 1'b1, 32'h40, fill(8'hA5), 2);
    do_access(1'b1, 1'b0, 32'h5F, '0, 3);
    // Back-to-back reads, re-raised right after o_ready falls
    do_access(1'b1, 1'b0, 32'h40, '0, 0);
    do_access(1'b1, 1'b0, 32'h41, '0, 1);

    // Out-of-range read at exactly the memory size, then original line intact
    do_access(1'b1, 1'b0, LIMIT, '0, 1);
    do_access(1'b1, 1'b0, 32'h40, '0, 0);

    // Conflicting read+write: error after one BUSY cycle, no update
    do_access(1'b1, 1'b1, 32'h40, fill(8'hEE), 1);
    do_access(1'b1, 1'b0, 32'h40, '0, 0);

    // Reset in the second BUSY cycle aborts the write
    do_access(1'b0, 1'b1, 32'h80, fill(8'h33), 0);
    i_write = 1'b1; i_address = 32'h80; i_data = fill(8'h11);
    @(posedge i_clock); #1;
    check("abort_busy", LW'(o_busy), LW'(1));
    @(posedge i_clock); #1;
    i_reset = 1'b1; i_write = 1'b0;
    @(posedge i_clock); #1;
    check("abort_ready", LW'(o_ready), LW'(0));
    check("abort_done",  LW'(o_done),  LW'(0));
    check("abort_error", LW'(o_error), LW'(0));
    check("abort_busy0", LW'(o_busy),  LW'(0));
    check("abort_data",  o_data,       LW'(0));
    i_reset = 1'b0;
    repeat (LAT + 2) @(posedge i_clock);
    #1;
    check("abort_no_done", LW'(o_done), LW'(0));
    check("abort_idle",    LW'(o_busy), LW'(0));
    do_access(1'b1, 1'b0, 32'h80, '0, 0);

    // Write withdrawn during BUSY still commits, RESP lasts one cycle
    start_req(1'b0, 1'b1, 32'h60, fill(8'h5A));
    wait_resp(1, 1'b1);
    release_resp(0);
    do_access(1'b1, 1'b0, 32'h60, '0, 0);

    // Request switched in the RESP exit cycle is not accepted on that edge
    start_req(1'b1, 1'b0, 32'h60, '0);
    wait_resp(1, 1'b0);
    start_req(1'b0, 1'b1, 32'hC0, fill(8'h77));
    @(posedge i_clock); #1;
    check("exit_no_accept", LW'(o_busy),  LW'(0));
    check("exit_ready_low", LW'(o_ready), LW'(0));
    wait_resp(1, 1'b0);
    release_resp(1);
    do_access(1'b1, 1'b0, 32'hC0, '0, 0);

    // Boundaries: last line in range, out-of-range writes leave line 0 alone
    do_access(1'b0, 1'b1, LIMIT - 1, fill(8'h3C), 0);
    do_access(1'b1, 1'b0, LIMIT - 32, '0, 0);
    do_access(1'b0, 1'b1, 32'h0, fill(8'h0F), 0);
    do_access(1'b0, 1'b1, LIMIT, fill(8'hF0), 1);
    do_access(1'b0, 1'b1, 32'hFFFF_FFE0, fill(8'hC3), 0);
    do_access(1'b1, 1'b0, 32'h1F, '0, 0);

    // Random in-range write/read pairs
    for (int k = 0; k < 4; k++) begin
      ra = AW'($urandom_range(0, int'(LIMIT) - 1));
      rd = {8{$urandom}};
      do_access(1'b0, 1'b1, ra, rd, int'($urandom_range(0, 2)));
      do_access(1'b1, 1'b0, ra ^ 32'h1F, '0, int'($urandom_range(0, 2)));
    end

    check("scoreboard_drained", LW'(sb.size()), LW'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte-address width of the memory bus.
REQ-002 Parameter LINE_WIDTH, default 256, data width of one memory line (bits, power of two, >=32).
REQ-003 Parameter DEPTH_LINES, default 1024, number of lines stored (power of two).
REQ-004 Parameter LATENCY, default 4, BUSY cycles per access (>=1).
REQ-005 i_clock  input  1  sole clock; all state updates on rising edge.
REQ-006 i_reset  input  1  synchronous, active-high reset.
REQ-007 i_address  input  ADDR_WIDTH  byte address of the requested line.
REQ-008 i_read  input  1  read request, level, held by initiator until o_ready.
REQ-009 i_write  input  1  write request, level, held by initiator until o_done.
REQ-010 i_data  input  LINE_WIDTH  write data.
REQ-011 o_data  output  LINE_WIDTH  read data, valid while o_ready=1.
REQ-012 o_ready  output  1  read complete.
REQ-013 o_done  output  1  write complete.
REQ-014 o_error  output  1  access rejected; qualifies o_ready/o_done.
REQ-015 o_busy  output  1  high in BUSY and RESP.

Function
REQ-016 FSM states IDLE, BUSY, RESP; all outputs registered.
REQ-017 Offset bits OFF=log2(LINE_WIDTH/8); line index = i_address[OFF+log2(DEPTH_LINES)-1:OFF]; low OFF bits ignored.
REQ-018 IDLE: on edge with i_read^i_write=1, latch address, data, kind; load counter LATENCY-1; go BUSY.
REQ-019 BUSY lasts exactly LATENCY cycles; counter decrements each edge; on edge with counter=0 go RESP.
REQ-020 Inputs changing during BUSY/RESP are ignored; latched values are used.
REQ-021 On BUSY->RESP edge, read: o_data<=line, o_ready<=1; write: line<=latched data, o_done<=1.
REQ-022 Out of range (latched address >= DEPTH_LINES*LINE_WIDTH/8): no memory update, o_data<=0, o_error<=1 with o_ready or o_done as per kind.
REQ-023 i_read and i_write both high in IDLE: accepted as error access, LATENCY skipped, RESP entered next edge with o_error=1, o_ready=1, o_done=1, no memory update.
REQ-024 RESP holds outputs while originating request (or either, for REQ-023) stays high; on edge with it low, clear o_ready/o_done/o_error/o_data, go IDLE.
REQ-025 No new request accepted in the cycle RESP exits; earliest acceptance is the following IDLE edge.
REQ-026 Request withdrawn during BUSY: access still completes (write committed); RESP lasts exactly one cycle.
REQ-027 Throughput: one access per LATENCY+2 cycles minimum.
REQ-028 Memory contents uninitialised at power-up; no read-modify-write, whole-line writes only.

Reset
REQ-029 i_reset=1 on an edge: state<=IDLE, counter<=0, o_data<=0, o_ready/o_done/o_error/o_busy<=0; takes priority over all transitions.
REQ-030 Reset mid-BUSY aborts access with no memory update; memory array never cleared by reset.

Verification
REQ-031 Write 0xA5..A5 to 0x40, hold i_write -> o_done rises LATENCY+1 edges after acceptance, o_error=0; drop i_write -> o_done low next edge.
REQ-032 Then read 0x5F (same line) -> o_ready after LATENCY+1 edges, o_data=0xA5..A5, held until i_read low.
REQ-033 Read address DEPTH_LINES*LINE_WIDTH/8 -> o_ready=1, o_error=1, o_data=0; subsequent read 0x40 still returns 0xA5..A5.
REQ-034 i_read=i_write=1 in IDLE -> next-next edge o_ready=o_done=o_error=1; line 0x40 unchanged.
REQ-035 Write 0x11..11 to 0x80, assert i_reset on second BUSY cycle -> all outputs 0, IDLE; read 0x80 returns prior content, not 0x11..11.
REQ-036 Back-to-back reads, i_read re-raised immediately after o_ready falls -> acceptance no earlier than REQ-025; changing i_address during BUSY does not affect o_data.
